// File: rtl/monostable_multi_pkg.sv
// Shared definitions for the multi-channel monostable.
// FSM state encoding and synchroniser depth.
package monostable_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } mono_state_t;

   localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/mono_channel.sv
// One monostable channel: synchroniser, rise detect, FSM and tick counter.
// Define MONO_RETRIG_EN to let a new rise during RUN restart the pulse.
module mono_channel
   import monostable_multi_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             qzt_clk,
   input  logic             rst_n,
   input  logic             i_tick,
   input  logic             i_trigger,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_out,
   output logic             o_done,
   output logic             o_busy
);

   logic [SYNC_DEPTH-1:0] r_sync;
   logic                  r_dly;
   mono_state_t           r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [CNT_W-1:0]      r_lim_q;
   logic                  r_out;
   logic                  r_done;

   logic                  w_sync;
   logic                  w_rise;
   logic                  w_lim_ok;
   logic [CNT_W-1:0]      w_lim_m1;
   logic                  w_last;

   assign w_sync   = r_sync[SYNC_DEPTH-1];
   assign w_rise   = w_sync & ~r_dly;
   assign w_lim_ok = |i_limit;
   assign w_lim_m1 = r_lim_q - 1'b1;
   assign w_last   = (r_cnt == w_lim_m1);

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_dly  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_DEPTH-2:0], i_trigger};
         r_dly  <= w_sync;
      end
   end

   always_ff @(posedge qzt_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_lim_q <= '0;
         r_out   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_rise && w_lim_ok) begin
                  r_state <= ST_RUN;
                  r_cnt   <= '0;
                  r_lim_q <= i_limit;
                  r_out   <= 1'b1;
               end
            end
            ST_RUN: begin
`ifdef MONO_RETRIG_EN
               if (w_rise && w_lim_ok) begin
                  r_cnt   <= '0;
                  r_lim_q <= i_limit;
               end else
`endif
               if (i_tick) begin
                  // cnt never reaches lim_q, so no wrap
                  if (w_last) begin
                     r_out   <= 1'b0;
                     r_done  <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= w_sync ? ST_HOLD : ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (!w_sync) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_out   <= 1'b0;
            end
         endcase
      end
   end

   assign o_out  = r_out;
   assign o_done = r_done;
   assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/monostable_multi.sv
// Multi-channel monostable top: CHANNELS independent mono_channel slices.
// Define MONO_RETRIG_EN to make every channel retriggerable during RUN.
module monostable_multi
   import monostable_multi_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 8
) (
   input  logic                qzt_clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [CHANNELS-1:0] trigger,
   input  logic [CNT_W-1:0]    limit,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] done,
   output logic                busy
);

   logic [CHANNELS-1:0] w_busy;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      mono_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .qzt_clk   (qzt_clk),
         .rst_n     (rst_n),
         .i_tick    (tick),
         .i_trigger (trigger[g]),
         .i_limit   (limit),
         .o_out     (out[g]),
         .o_done    (done[g]),
         .o_busy    (w_busy[g])
      );
   end

   assign busy = |w_busy;

endmodule

// File: tb/tb_monostable_multi.sv
// Scoreboard bench for monostable_multi: directed cases plus random traffic.
module tb_monostable_multi;

   localparam int CH = 4;
   localparam int CW = 8;
`ifdef MONO_RETRIG_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   logic          qzt_clk = 1'b0;
   logic          rst_n   = 1'b0;
   logic          tick    = 1'b0;
   logic [CH-1:0] trigger = '0;
   logic [CW-1:0] limit   = '0;
   logic [CH-1:0] out;
   logic [CH-1:0] done;
   logic          busy;

   always #5 qzt_clk = ~qzt_clk;

   monostable_multi #(
      .CHANNELS (CH),
      .CNT_W    (CW)
   ) dut (
      .qzt_clk (qzt_clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .trigger (trigger),
      .limit   (limit),
      .out     (out),
      .done    (done),
      .busy    (busy)
   );

   typedef struct packed {
      logic [CH-1:0] o;
      logic [CH-1:0] d;
      logic          b;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference: trigger history, and per channel a pulse that owes m_rem ticks
   logic [CH-1:0] hist[$];
   bit            m_run[CH];
   bit            m_hold[CH];
   int            m_rem[CH];
   logic [CH-1:0] m_done;

   function void model_reset();
      hist = {};
      repeat (3) hist.push_back('0);
      for (int c = 0; c < CH; c++) begin
         m_run[c]  = 1'b0;
         m_hold[c] = 1'b0;
         m_rem[c]  = 0;
      end
      m_done = '0;
   endfunction

   always @(negedge rst_n) model_reset();

   always @(posedge qzt_clk) begin
      exp_t e;
      bit   s;
      bit   r;
      if (!rst_n) begin
         model_reset();
      end else begin
         m_done = '0;
         for (int c = 0; c < CH; c++) begin
            s = hist[1][c];
            r = hist[1][c] & ~hist[2][c];
            if (m_run[c]) begin
               if (RETRIG && r && limit != 0) begin
                  m_rem[c] = int'(limit);
               end else if (tick) begin
                  m_rem[c] = m_rem[c] - 1;
                  if (m_rem[c] == 0) begin
                     m_run[c]  = 1'b0;
                     m_done[c] = 1'b1;
                     m_hold[c] = s;
                  end
               end
            end else if (m_hold[c]) begin
               if (!s) m_hold[c] = 1'b0;
            end else if (r && limit != 0) begin
               m_run[c] = 1'b1;
               m_rem[c] = int'(limit);
            end
         end
         hist.push_front(trigger);
         void'(hist.pop_back());
      end
      for (int c = 0; c < CH; c++) begin
         e.o[c] = m_run[c];
      end
      e.d = m_done;
      e.b = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (m_run[c] || m_hold[c]) e.b = 1'b1;
      end
      exp_q.push_back(e);
   end

   int cur_len[CH];
   int last_len[CH];
   int npulse[CH];

   always @(negedge qzt_clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_tests++;
         if ({out, done, busy} !== e) begin
            n_fail++;
            $display("FAIL cycle_vec t=%0t out=%b done=%b busy=%b expected out=%b done=%b busy=%b",
                     $time, out, done, busy, e.o, e.d, e.b);
         end
      end
      for (int c = 0; c < CH; c++) begin
         if (!rst_n) begin
            cur_len[c] = 0;
         end else begin
            if (out[c]) cur_len[c]++;
            if (done[c]) begin
               last_len[c] = cur_len[c];
               npulse[c]++;
               cur_len[c] = 0;
            end
         end
      end
   end

   task automatic check(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge qzt_clk);
   endtask

   initial begin
      int bc;
      int np_prev;
      for (int c = 0; c < CH; c++) begin
         cur_len[c]  = 0;
         last_len[c] = 0;
         npulse[c]   = 0;
      end
      step(3);
      check("reset_out", int'(out), 0);
      check("reset_done", int'(done), 0);
      check("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      tick  = 1'b1;
      step(2);

      limit      = 8'd5;
      trigger[0] = 1'b1;
      step();
      check("lat_edge1", int'(out[0]), 0);
      step();
      check("lat_edge2", int'(out[0]), 0);
      step();
      check("lat_edge3", int'(out[0]), 1);
      trigger[0] = 1'b0;
      step(10);
      check("basic_len", last_len[0], 5);
      check("basic_cnt", npulse[0], 1);

      limit      = 8'd3;
      trigger[1] = 1'b1;
      step(40);
      check("hold_out", int'(out[1]), 0);
      check("hold_busy", int'(busy), 1);
      trigger[1] = 1'b0;
      step(6);
      check("hold_cnt", npulse[1], 1);
      check("hold_len", last_len[1], 3);
      check("hold_idle", int'(busy), 0);

      limit      = 8'd0;
      trigger[2] = 1'b1;
      step(10);
      check("lim0_cnt", npulse[2], 0);
      check("lim0_busy", int'(busy), 0);
      trigger[2] = 1'b0;
      step(4);

      limit      = 8'd4;
      trigger[2] = 1'b1;
      step();
      trigger[2] = 1'b0;
      step(4);
      limit = 8'd9;
      step(10);
      check("midchg_len", last_len[2], 4);
      check("midchg_cnt", npulse[2], 1);

      limit   = 8'd6;
      trigger = 4'b1001;
      step();
      trigger = '0;
      step(2);
      check("indep_both", int'(out[0] & out[3]), 1);
      bc = 0;
      repeat (12) begin
         if (busy) bc++;
         step();
      end
      check("indep_busy", bc, 6);
      check("indep_len0", last_len[0], 6);
      check("indep_len3", last_len[3], 6);

      limit      = 8'd5;
      trigger[2] = 1'b1;
      step();
      trigger[2] = 1'b0;
      step(2);
      trigger[2] = 1'b1;
      step(20);
      trigger[2] = 1'b0;
      step(5);
      check("retrig_len", last_len[2], RETRIG ? 8 : 5);
      check("retrig_cnt", npulse[2], 2);

      np_prev    = npulse[0];
      limit      = 8'd5;
      trigger[0] = 1'b1;
      step(5);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out", int'(out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      trigger = '0;
      step(2);
      rst_n = 1'b1;
      step(10);
      check("rst_nodone", npulse[0], np_prev);

      repeat (3000) begin
         tick = ($urandom_range(0, 2) == 0);
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 7) == 0) trigger[c] = ~trigger[c];
         end
         if ($urandom_range(0, 15) == 0) limit = 8'($urandom_range(0, 6));
         step();
      end
      trigger = '0;
      tick    = 1'b1;
      step(20);
      check("drain_busy", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
